// File: rtl/mem_responder.sv
// Fixed-latency word memory responder with a ready/valid handshake for a multi-cycle CPU.
// Optional MISALIGN_ERR_EN adds misaligned_err and suppresses misaligned accesses.
module mem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 16384,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  is_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  is_output_valid,
    output logic                  write_done
`ifdef MISALIGN_ERR_EN
    ,
    output logic                  misaligned_err
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_WORDS);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_finish;
    logic                  w_ok;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_is_write;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;
    logic                  r_wdone;
    logic                  r_mis;
    logic                  r_mis_err;
    logic                  w_unused_addr;

    logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];

    // Only the word index (and, with the feature, the byte offset) matters.
    assign w_unused_addr = ^addr;

`ifdef MISALIGN_ERR_EN
    assign w_ok           = ~r_mis;
    assign misaligned_err = r_mis_err;
`else
    assign w_ok = 1'b1;
`endif

    assign is_ready        = r_ready;
    assign dout            = r_dout;
    assign is_output_valid = r_valid;
    assign write_done      = r_wdone;

    // Next-state decode.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    w_next   = BUSY;
                    w_accept = 1'b1;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_next   = RESP;
                    w_finish = 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_finish && r_is_write && w_ok) begin
            r_mem[r_idx] <= r_din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_din      <= '0;
            r_is_write <= 1'b0;
            r_mis      <= 1'b0;
            r_ready    <= 1'b1;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_wdone    <= 1'b0;
            r_mis_err  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ready   <= (w_next == IDLE);
            r_valid   <= w_finish && !r_is_write;
            r_wdone   <= w_finish && r_is_write;
            r_mis_err <= w_finish && r_mis;
            if (w_accept) begin
                r_idx      <= addr[2 +: IDX_W];
                r_din      <= din;
                r_is_write <= mem_write;
                r_mis      <= (addr[1:0] != 2'b00);
                r_cnt      <= CNT_W'(LATENCY - 1);
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_finish && !r_is_write) begin
                r_dout <= w_ok ? r_mem[r_idx] : '0;
            end
        end
    end

endmodule
